// File: rtl/lzrw_block_serializer.sv
// Block-to-byte serializer feeding the LZRW byte-serial datapath.
// Whole blocks (with an effective byte count and end-of-stream flag) are
// buffered in a small ring and emitted one byte per ready/valid transfer,
// byte 0 first. The last byte of each block raises finished_cycle, and the
// last byte of the stream also raises out_last.
module lzrw_block_serializer #(
  parameter int BYTES_PER_BLOCK = 16,
  parameter int BYTE_W          = 8,
  parameter int DEPTH           = 2,
  parameter int CNT_W           = 16,
  localparam int CW             = $clog2(BYTES_PER_BLOCK + 1)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [BYTES_PER_BLOCK*BYTE_W-1:0] in_block,
  input  logic [CW-1:0]                     in_count,
  input  logic                              in_last,
  output logic [BYTE_W-1:0]                 out_byte,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              finished_cycle,
  output logic                              out_last,
  output logic [CNT_W-1:0]                  blocks_done
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(BYTES_PER_BLOCK);
  localparam int BW = BYTES_PER_BLOCK * BYTE_W;

  // Ring storage; payload is not reset because occupancy qualifies it.
  logic [BW-1:0]    block_mem_r [DEPTH];
  logic [CW-1:0]    count_mem_r [DEPTH];
  logic [DEPTH-1:0] last_mem_r;

  logic [OW-1:0]    occ_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [IW-1:0]    idx_r;
  logic [CNT_W-1:0] blocks_done_r;

  logic [CW-1:0]     eff_count_s;
  logic [CW-1:0]     head_count_s;
  logic [BYTE_W-1:0] head_bytes_s [BYTES_PER_BLOCK];
  logic              push_s;
  logic              xfer_s;
  logic              pop_s;

  // Ring pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of 2).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return PW'(0);
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Effective count: zero means a full block, oversize values clamp to a full block.
  always_comb begin
    eff_count_s = in_count;
    if ((in_count == CW'(0)) || (in_count > CW'(BYTES_PER_BLOCK))) begin
      eff_count_s = CW'(BYTES_PER_BLOCK);
    end else begin
      eff_count_s = in_count;
    end
  end

  // Split the head block into addressable bytes.
  always_comb begin
    head_count_s = count_mem_r[rd_ptr_r];
    for (int k = 0; k < BYTES_PER_BLOCK; k++) begin
      head_bytes_s[k] = block_mem_r[rd_ptr_r][k*BYTE_W +: BYTE_W];
    end
  end

  // Handshake and output decode from registered state; everything quiet in reset.
  always_comb begin
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    out_byte       = {BYTE_W{1'b0}};
    finished_cycle = 1'b0;
    out_last       = 1'b0;
    if (reset) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
    end else begin
      // No pop-to-push pass-through: readiness looks at stored occupancy only.
      in_ready  = (occ_r < OW'(DEPTH));
      out_valid = (occ_r != OW'(0));
      if (out_valid) begin
        out_byte       = head_bytes_s[idx_r];
        finished_cycle = (CW'(idx_r) == (head_count_s - CW'(1)));
        out_last       = finished_cycle && last_mem_r[rd_ptr_r];
      end else begin
        out_byte       = {BYTE_W{1'b0}};
        finished_cycle = 1'b0;
        out_last       = 1'b0;
      end
    end
  end

  assign push_s      = in_valid && in_ready;
  assign xfer_s      = out_valid && out_ready;
  assign pop_s       = xfer_s && finished_cycle;
  assign blocks_done = blocks_done_r;

  // Control state: occupancy, ring pointers, byte index and completed-block count.
  always_ff @(posedge clock) begin
    if (reset) begin
      occ_r         <= OW'(0);
      wr_ptr_r      <= PW'(0);
      rd_ptr_r      <= PW'(0);
      idx_r         <= IW'(0);
      blocks_done_r <= CNT_W'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end

      if (pop_s) begin
        rd_ptr_r      <= ptr_inc(rd_ptr_r);
        idx_r         <= IW'(0);
        blocks_done_r <= blocks_done_r + CNT_W'(1);
      end else if (xfer_s) begin
        idx_r <= idx_r + IW'(1);
      end else begin
        idx_r <= idx_r;
      end

      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OW'(1);
        2'b01:   occ_r <= occ_r - OW'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Capture an accepted block with its effective count and end-of-stream flag.
  always_ff @(posedge clock) begin
    if (push_s) begin
      block_mem_r[wr_ptr_r] <= in_block;
      count_mem_r[wr_ptr_r] <= eff_count_s;
      last_mem_r[wr_ptr_r]  <= in_last;
    end
  end

endmodule
